// File: rtl/boid_pkg.sv
// Shared types and constants for the boid accelerator datapath.
// Holds the default fixed-point format, range constants and the accumulator FSM encoding.
package boid_pkg;

    localparam int BOID_W      = 32;
    localparam int BOID_FRAC   = 16;
    localparam int PROT_R_DEF  = 8;
    localparam int VIS_R_DEF   = 40;

    typedef logic signed [BOID_W-1:0] fix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_e;

endpackage

// File: rtl/boid_dist_est.sv
// Distance estimate helpers: saturating abs of the deltas (stage 1) and the
// alpha-max-beta-min estimate max + min/2 of the registered magnitudes (stage 2).
module boid_dist_est
    import boid_pkg::*;
#(
    parameter int W = BOID_W
) (
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    output logic        [W-1:0] adx,
    output logic        [W-1:0] ady,
    input  logic        [W-1:0] mag_a,
    input  logic        [W-1:0] mag_b,
    output logic        [W:0]   est
);

    // The most negative value has no positive twin; clamp it to the largest positive.
    function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        return v[W-1] ? W'(-v) : W'(v);
    endfunction

    logic [W-1:0] hi;
    logic [W-1:0] lo;

    assign adx = sat_abs(dx);
    assign ady = sat_abs(dy);

    assign hi  = (mag_a >= mag_b) ? mag_a : mag_b;
    assign lo  = (mag_a >= mag_b) ? mag_b : mag_a;
    assign est = {1'b0, hi} + {2'b00, lo[W-1:1]};

endmodule

// File: rtl/boid_neigh_accum.sv
// Streaming neighbour accumulator: latches a self boid, classifies each incoming
// neighbour as protected/visual/ignored and presents per-frame sums on a valid/ready output.
module boid_neigh_accum
    import boid_pkg::*;
#(
    parameter int W         = BOID_W,
    parameter int FRAC      = BOID_FRAC,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 6,
    parameter int PROT_R    = PROT_R_DEF,
    parameter int VIS_R     = VIS_R_DEF,
    parameter int SKIP_SELF = 1,
    localparam int ACC_W    = W + CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [W-1:0]     self_x,
    input  logic signed [W-1:0]     self_y,
    input  logic signed [W-1:0]     self_vx,
    input  logic signed [W-1:0]     self_vy,
    input  logic        [IDX_W-1:0] self_idx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_x,
    input  logic signed [W-1:0]     in_y,
    input  logic signed [W-1:0]     in_vx,
    input  logic signed [W-1:0]     in_vy,
    input  logic        [IDX_W-1:0] in_idx,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] close_dx,
    output logic signed [ACC_W-1:0] close_dy,
    output logic signed [ACC_W-1:0] avg_x,
    output logic signed [ACC_W-1:0] avg_y,
    output logic signed [ACC_W-1:0] avg_vx,
    output logic signed [ACC_W-1:0] avg_vy,
    output logic        [CNT_W-1:0] neigh_cnt,
    output logic                    cnt_ovf,
    output logic                    busy
);

    localparam logic [W:0]       PROT_LIM = (W+1)'(PROT_R) << FRAC;
    localparam logic [W:0]       VIS_LIM  = (W+1)'(VIS_R) << FRAC;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    fsm_e               state;
    logic signed [W-1:0] sx, sy;
    logic [IDX_W-1:0]   sidx;
    logic [2:1]         vld_pipe;
    logic               fire;
    logic               clr;

    logic signed [W-1:0] dx, dy;
    logic [W-1:0]       adx, ady;
    logic [W:0]         est;
    logic               is_prot, is_vis;

    logic signed [W-1:0] s1_dx, s1_dy, s1_x, s1_y, s1_vx, s1_vy;
    logic [W-1:0]       s1_adx, s1_ady;
    logic               s1_skip;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign fire      = in_valid & in_ready;
    assign clr       = (state == IDLE) & start;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sx    <= '0;
            sy    <= '0;
            sidx  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ACCUM;
                    sx    <= self_x;
                    sy    <= self_y;
                    sidx  <= self_idx;
                end
                ACCUM: if (fire && in_last) state <= DRAIN;
                DRAIN: if (vld_pipe == '0) state <= DONE;
                DONE:  if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Self velocity only matters downstream; accepted but not needed for these sums.
    logic unused_self_v;
    assign unused_self_v = ^{self_vx, self_vy};

    assign dx = in_x - sx;
    assign dy = in_y - sy;

    boid_dist_est #(.W(W)) u_est (
        .dx    (dx),
        .dy    (dy),
        .adx   (adx),
        .ady   (ady),
        .mag_a (s1_adx),
        .mag_b (s1_ady),
        .est   (est)
    );

    always_ff @(posedge clk) begin
        if (!reset) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[1], fire};
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            s1_dx   <= dx;
            s1_dy   <= dy;
            s1_adx  <= adx;
            s1_ady  <= ady;
            s1_x    <= in_x;
            s1_y    <= in_y;
            s1_vx   <= in_vx;
            s1_vy   <= in_vy;
            s1_skip <= (SKIP_SELF != 0) && (in_idx == sidx);
        end
    end

    assign is_prot = (est < PROT_LIM);
    assign is_vis  = (est < VIS_LIM);

    // Protected sums keep accumulating after the visual counter saturates.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            close_dx  <= '0;
            close_dy  <= '0;
            avg_x     <= '0;
            avg_y     <= '0;
            avg_vx    <= '0;
            avg_vy    <= '0;
            neigh_cnt <= '0;
            cnt_ovf   <= 1'b0;
        end else if (vld_pipe[1] && !s1_skip) begin
            if (is_prot) begin
                close_dx <= close_dx - ACC_W'(s1_dx);
                close_dy <= close_dy - ACC_W'(s1_dy);
            end else if (is_vis) begin
                if (neigh_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    avg_x     <= avg_x  + ACC_W'(s1_x);
                    avg_y     <= avg_y  + ACC_W'(s1_y);
                    avg_vx    <= avg_vx + ACC_W'(s1_vx);
                    avg_vy    <= avg_vy + ACC_W'(s1_vy);
                    neigh_cnt <= neigh_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boid_neigh_accum.sv
// Bench for boid_neigh_accum: two instances (default and CNT_W=2) on shared stimulus,
// checked against a per-beat arithmetic reference of the distance classification.
module tb_boid_neigh_accum;

    localparam int FR = 65536;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic signed [31:0] self_x = '0, self_y = '0, self_vx = '0, self_vy = '0;
    logic signed [31:0] in_x = '0, in_y = '0, in_vx = '0, in_vy = '0;
    logic [5:0] self_idx = '0, in_idx = '0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;

    logic a_in_ready, a_out_valid, a_busy, a_ovf;
    logic signed [39:0] a_cdx, a_cdy, a_ax, a_ay, a_avx, a_avy;
    logic [7:0] a_cnt;
    logic b_in_ready, b_out_valid, b_busy, b_ovf;
    logic signed [33:0] b_cdx, b_cdy, b_ax, b_ay, b_avx, b_avy;
    logic [1:0] b_cnt;

    logic [248:0] got_a;
    logic [206:0] got_b;
    assign got_a = {a_cdx, a_cdy, a_ax, a_ay, a_avx, a_avy, a_cnt, a_ovf};
    assign got_b = {b_cdx, b_cdy, b_ax, b_ay, b_avx, b_avy, b_cnt, b_ovf};

    boid_neigh_accum dut (
        .clk(clk), .reset(reset), .start(start),
        .self_x(self_x), .self_y(self_y), .self_vx(self_vx), .self_vy(self_vy), .self_idx(self_idx),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_x(in_x), .in_y(in_y), .in_vx(in_vx), .in_vy(in_vy), .in_idx(in_idx), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .close_dx(a_cdx), .close_dy(a_cdy), .avg_x(a_ax), .avg_y(a_ay), .avg_vx(a_avx), .avg_vy(a_avy),
        .neigh_cnt(a_cnt), .cnt_ovf(a_ovf), .busy(a_busy)
    );

    boid_neigh_accum #(.CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .start(start),
        .self_x(self_x), .self_y(self_y), .self_vx(self_vx), .self_vy(self_vy), .self_idx(self_idx),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x), .in_y(in_y), .in_vx(in_vx), .in_vy(in_vy), .in_idx(in_idx), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .close_dx(b_cdx), .close_dy(b_cdy), .avg_x(b_ax), .avg_y(b_ay), .avg_vx(b_avx), .avg_vy(b_avy),
        .neigh_cnt(b_cnt), .cnt_ovf(b_ovf), .busy(b_busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int sx, sy, svx, svy;
    logic [5:0] sidx;
    int bx[32], by[32], bvx[32], bvy[32];
    logic [5:0] bidx[32];

    typedef struct {
        longint cdx, cdy, ax, ay, avx, avy;
        longint cnt;
        bit     ovf;
    } res_t;

    function automatic longint mag(input int v);
        if (v == int'(32'h8000_0000)) return 64'd2147483647;
        return (v < 0) ? -longint'(v) : longint'(v);
    endfunction

    // Reference: classify every beat from the geometric rules and sum the contributions.
    function automatic res_t model(input int n, input longint cmax);
        res_t r;
        r.cdx = 0; r.cdy = 0; r.ax = 0; r.ay = 0; r.avx = 0; r.avy = 0; r.cnt = 0; r.ovf = 0;
        for (int i = 0; i < n; i++) begin
            int dx, dy;
            longint mx, my, est;
            if (bidx[i] == sidx) continue;
            dx  = bx[i] - sx;
            dy  = by[i] - sy;
            mx  = mag(dx);
            my  = mag(dy);
            est = (mx > my) ? mx + my / 2 : my + mx / 2;
            if (est < 8 * FR) begin
                r.cdx -= dx;
                r.cdy -= dy;
            end else if (est < 40 * FR) begin
                if (r.cnt == cmax) r.ovf = 1;
                else begin
                    r.ax += bx[i]; r.ay += by[i]; r.avx += bvx[i]; r.avy += bvy[i];
                    r.cnt++;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [248:0] pack_a(input res_t r);
        return {40'(r.cdx), 40'(r.cdy), 40'(r.ax), 40'(r.ay), 40'(r.avx), 40'(r.avy), 8'(r.cnt), r.ovf};
    endfunction

    function automatic logic [206:0] pack_b(input res_t r);
        return {34'(r.cdx), 34'(r.cdy), 34'(r.ax), 34'(r.ay), 34'(r.avx), 34'(r.avy), 2'(r.cnt), r.ovf};
    endfunction

    task automatic set_beat(input int i, input int x, input int y, input int vx, input int vy, input int idx);
        bx[i] = x * FR; by[i] = y * FR; bvx[i] = vx * FR; bvy[i] = vy * FR; bidx[i] = 6'(idx);
    endtask

    task automatic default_self();
        sx = 140 * FR; sy = 140 * FR; svx = 3 * FR; svy = 3 * FR; sidx = 6'd0;
    endtask

    task automatic gen_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int span;
            span   = (i % 3 == 0) ? 10 : (i % 3 == 1) ? 50 : 100;
            bx[i]  = sx + int'($urandom_range(0, 2 * span * FR)) - span * FR;
            by[i]  = sy + int'($urandom_range(0, 2 * span * FR)) - span * FR;
            bvx[i] = int'($urandom);
            bvy[i] = int'($urandom);
            bidx[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
    endtask

    // Start a frame from IDLE, stream n beats, report cycles from last transfer to out_valid.
    task automatic run_frame(input int n, input bit throttle, output int lat);
        self_x = sx; self_y = sy; self_vx = svx; self_vy = svy; self_idx = sidx;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (throttle && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_x = bx[i]; in_y = by[i]; in_vx = bvx[i]; in_vy = bvy[i];
            in_idx = bidx[i]; in_last = (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (got_a !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got_a); end
        checks++; if (got_b !== '0) begin errors++; $display("FAIL reset_outputs_c2 got=%h exp=0", got_b); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [248:0] ea;
        default_self();
        set_beat(0, 150, 140, 3, 3, 1);
        set_beat(1, 141, 141, 3, 3, 2);
        set_beat(2, 180, 180, 3, 3, 3);
        run_frame(3, 1'b0, lat);
        ea = pack_a(model(3, 255));
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (a_cdx !== -40'sd65536) begin errors++; $display("FAIL basic_close_dx got=%h exp=%h", a_cdx, -40'sd65536); end
        checks++; if (a_ax !== 40'(150 * FR)) begin errors++; $display("FAIL basic_avg_x got=%h exp=%h", a_ax, 40'(150 * FR)); end
        checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", a_cnt); end
        checks++; if (got_a !== ea) begin errors++; $display("FAIL basic_sums got=%h exp=%h", got_a, ea); end
        checks++; if (got_b !== pack_b(model(3, 3))) begin errors++; $display("FAIL basic_sums_c2 got=%h exp=%h", got_b, pack_b(model(3, 3))); end
        ack();
        checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b%b exp=00", a_busy, a_out_valid); end
        checks++; if (got_a !== ea) begin errors++; $display("FAIL basic_hold_idle got=%h exp=%h", got_a, ea); end
    endtask

    task automatic test_visual();
        int lat;
        default_self();
        set_beat(0, 140, 150, -3, 3, 1);
        set_beat(1, 150, 150, 3, -3, 2);
        run_frame(2, 1'b0, lat);
        checks++; if (a_ax !== 40'(290 * FR) || a_ay !== 40'(300 * FR)) begin errors++; $display("FAIL visual_avg_xy got=%h,%h exp=%h,%h", a_ax, a_ay, 40'(290 * FR), 40'(300 * FR)); end
        checks++; if (a_avx !== '0 || a_avy !== '0 || a_cnt !== 8'd2) begin errors++; $display("FAIL visual_v_cnt got=%h,%h,%0d exp=0,0,2", a_avx, a_avy, a_cnt); end
        checks++; if (got_a !== pack_a(model(2, 255))) begin errors++; $display("FAIL visual_sums got=%h exp=%h", got_a, pack_a(model(2, 255))); end
        ack();
    endtask

    task automatic test_skip_self();
        int lat;
        default_self();
        set_beat(0, 140, 140, 3, 3, 0);
        set_beat(1, 148, 140, 3, 3, 1);
        run_frame(2, 1'b0, lat);
        checks++; if (a_cnt !== 8'd1 || a_cdx !== '0 || a_cdy !== '0) begin errors++; $display("FAIL skip_self got=cnt%0d close=%h,%h exp=cnt1 close=0,0", a_cnt, a_cdx, a_cdy); end
        checks++; if (got_a !== pack_a(model(2, 255))) begin errors++; $display("FAIL skip_self_sums got=%h exp=%h", got_a, pack_a(model(2, 255))); end
        ack();
        // A frame whose only beat is the self beat with in_last must still end.
        bidx[0] = 6'd0; bx[0] = sx; by[0] = sy;
        run_frame(1, 1'b0, lat);
        checks++; if (lat !== 3 || got_a !== '0) begin errors++; $display("FAIL skip_self_last got=lat%0d sums=%h exp=lat3 sums=0", lat, got_a); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [248:0] first, ea;
        sx = int'($urandom); sy = int'($urandom); svx = 0; svy = 0; sidx = 6'd5;
        gen_beats(10);
        run_frame(10, 1'b0, lat);
        first = got_a;
        ack();
        run_frame(10, 1'b1, lat);
        ea = pack_a(model(10, 255));
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        checks++; if (got_a !== first) begin errors++; $display("FAIL bp_vs_unthrottled got=%h exp=%h", got_a, first); end
        checks++; if (got_a !== ea) begin errors++; $display("FAIL bp_sums got=%h exp=%h", got_a, ea); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (a_out_valid !== 1'b1 || got_a !== ea) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%b %h exp=1 %h", c, a_out_valid, got_a, ea);
            end
        end
        ack();
    endtask

    task automatic test_saturation();
        int lat;
        default_self();
        for (int i = 0; i < 5; i++) set_beat(i, 150 + i, 140, i, 1, i + 1);
        set_beat(5, 141, 140, 0, 0, 9);
        run_frame(6, 1'b0, lat);
        checks++; if (b_cnt !== 2'd3 || b_ovf !== 1'b1) begin errors++; $display("FAIL sat_cnt got=%0d ovf=%b exp=3 ovf=1", b_cnt, b_ovf); end
        checks++; if (b_ax !== 34'(453 * FR)) begin errors++; $display("FAIL sat_avg_x got=%h exp=%h", b_ax, 34'(453 * FR)); end
        checks++; if (b_cdx !== -34'sd65536) begin errors++; $display("FAIL sat_prot_continues got=%h exp=%h", b_cdx, -34'sd65536); end
        checks++; if (got_b !== pack_b(model(6, 3))) begin errors++; $display("FAIL sat_sums_c2 got=%h exp=%h", got_b, pack_b(model(6, 3))); end
        checks++; if (a_cnt !== 8'd5 || a_ovf !== 1'b0) begin errors++; $display("FAIL sat_wide_cnt got=%0d ovf=%b exp=5 ovf=0", a_cnt, a_ovf); end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        default_self();
        set_beat(0, 150, 140, 3, 3, 1);
        set_beat(1, 141, 141, 3, 3, 2);
        self_x = sx; self_y = sy; self_vx = svx; self_vy = svy; self_idx = sidx;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_x = bx[i]; in_y = by[i]; in_vx = bvx[i]; in_vy = bvy[i]; in_idx = bidx[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got=%b%b%b exp=000", a_busy, a_in_ready, a_out_valid); end
        checks++; if (got_a !== '0) begin errors++; $display("FAIL rstmid_outputs got=%h exp=0", got_a); end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (got_a !== '0) begin errors++; $display("FAIL rstmid_flush got=%h exp=0", got_a); end
        set_beat(0, 160, 140, 1, 1, 3);
        set_beat(1, 139, 143, 2, 2, 4);
        run_frame(2, 1'b0, lat);
        checks++; if (got_a !== pack_a(model(2, 255))) begin errors++; $display("FAIL rstmid_new_frame got=%h exp=%h", got_a, pack_a(model(2, 255))); end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [248:0] ea;
        default_self();
        gen_beats(4);
        run_frame(4, 1'b0, lat);
        ea = pack_a(model(4, 255));
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_start_ignored got=busy%b ready%b exp=busy0 ready0", a_busy, a_in_ready); end
        checks++; if (got_a !== ea) begin errors++; $display("FAIL b2b_outputs_held got=%h exp=%h", got_a, ea); end
        gen_beats(5);
        run_frame(5, 1'b0, lat);
        checks++; if (lat !== 3 || got_a !== pack_a(model(5, 255))) begin errors++; $display("FAIL b2b_next_frame got=lat%0d %h exp=lat3 %h", lat, got_a, pack_a(model(5, 255))); end
        ack();
    endtask

    task automatic test_random();
        int lat, n;
        bit thr;
        for (int f = 0; f < 12; f++) begin
            sx = int'($urandom); sy = int'($urandom);
            svx = int'($urandom); svy = int'($urandom);
            sidx = 6'd0;
            n = int'($urandom_range(1, 16));
            thr = 1'($urandom_range(0, 1));
            gen_beats(n);
            if (f % 4 == 0) bx[0] = sx + int'(32'h8000_0000);
            run_frame(n, thr, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency frame=%0d got=%0d exp=3", f, lat); end
            checks++; if (got_a !== pack_a(model(n, 255))) begin errors++; $display("FAIL rand_sums frame=%0d got=%h exp=%h", f, got_a, pack_a(model(n, 255))); end
            checks++; if (got_b !== pack_b(model(n, 3))) begin errors++; $display("FAIL rand_sums_c2 frame=%0d got=%h exp=%h", f, got_b, pack_b(model(n, 3))); end
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_visual();
        test_skip_self();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
